// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done operand and result bundle for serial_subtractor; mode signal present only with SERSUB_ADD_MODE_EN
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERSUB_ADD_MODE_EN
    logic             mode;

    modport master (output start, a, b, bin, mode, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, mode, output busy, done, diff, bout);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit a-b-bin, LSB first; SERSUB_ADD_MODE_EN adds a mode input selecting a+b+cin
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic             last_bit;
    logic             add_sel;

`ifdef SERSUB_ADD_MODE_EN
    logic             mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            mode_q <= bus.mode;
        end
    end

    assign add_sel = mode_q;
`else
    assign add_sel = 1'b0;
`endif

    // One-bit slice: br is a borrow when subtracting and a carry when adding.
    always_comb begin
        a0 = a_sr[0];
        b0 = b_sr[0];
        d  = a0 ^ b0 ^ br;
        if (add_sel) begin
            br_next = (a0 & b0) | (br & (a0 ^ b0));
        end else begin
            br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
        end
    end

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_SHIFT;
            S_SHIFT: if (last_bit)  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_SHIFT);
        bus.done = (state == S_DONE);
        bus.diff = diff_q;
        bus.bout = bout_q;
    end

    // Operands are captured at acceptance so the inputs may change mid-operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sr <= bus.a;
                        b_sr <= bus.b;
                        br   <= bus.bin;
                        cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff_q <= {d, res_sr[WIDTH-1:1]};
                        bout_q <= br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector bench for serial_subtractor
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge E.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic mode);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
`ifdef SERSUB_ADD_MODE_EN
        bus.mode  = mode;
`else
        if (mode) $display("add mode requested without SERSUB_ADD_MODE_EN");
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.bin   = ~bin;
    endtask

    task automatic wait_check(input string tag, input logic [7:0] exp_diff, input logic exp_bout, input int exp_cyc);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) busy_cnt++;
            tick();
            cyc++;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
        check({tag, "_diff"}, 32'(bus.diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bus.bout), 32'(exp_bout));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        tick();
        check({tag, "_done_clears"}, 32'(bus.done), 32'd0);
        check({tag, "_diff_holds"}, 32'(bus.diff), 32'(exp_diff));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   extra_done;
        int   extra_busy;

        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
`ifdef SERSUB_ADD_MODE_EN
        bus.mode  = 1'b0;
`endif
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0);
            wait_check($sformatf("sub%0d", i), vecs[i].diff, vecs[i].bout, WIDTH);
        end

        // Second start during SHIFT must be ignored.
        start_op(8'h10, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        bus.a     = 8'h00;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_check("ignore", 8'h0F, 1'b0, WIDTH - 3);
        extra_done = 0;
        extra_busy = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) extra_done++;
            if (bus.busy) extra_busy++;
            tick();
        end
        check("ignore_no_second_done", 32'(extra_done), 32'd0);
        check("ignore_no_second_busy", 32'(extra_busy), 32'd0);

        // Reset mid-operation aborts with no done pulse.
        start_op(8'h05, 8'h03, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) extra_done++;
            tick();
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        start_op(8'h03, 8'h05, 1'b0, 1'b0);
        wait_check("after_abort", 8'hFE, 1'b1, WIDTH);

`ifdef SERSUB_ADD_MODE_EN
        start_op(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_check("add0", 8'h00, 1'b1, WIDTH);
        start_op(8'h7F, 8'h01, 1'b1, 1'b1);
        wait_check("add1", 8'h81, 1'b0, WIDTH);
        start_op(8'h7F, 8'h01, 1'b1, 1'b0);
        wait_check("mode0_sub", 8'h7D, 1'b0, WIDTH);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor built around a registered one-bit full-subtractor slice.
- Computes diff = a - b - bin, LSB first, one bit per clock.
- Start/done handshake; final result and borrow-out are registered.
- Complements the combinational adder datapath: a small-area arithmetic unit for lab designs and a reusable sequential stage.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- bin  input  1  borrow-in; captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered result.
- bout  output  1  registered final borrow-out.

Behaviour:
- Reset, asynchronous and active-low, sets:
  - state=IDLE.
  - busy, done, diff, bout, bit counter and internal shift registers all 0.
  - Reset wins over every other event.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - On a clock edge with start=1, load a and b into shift registers, load the borrow register with bin, clear the counter, and go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - Bit slice on the LSBs a0, b0 and borrow register br: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
  - Shift the a and b registers right by one.
  - Shift d into the MSB of the result shift register.
  - Increment the counter.
  - On the edge that processes bit WIDTH-1:
    - Copy the full result shift register (including that bit) to diff and br_next to bout.
    - Set done=1 and go to DONE.
- DONE: on the next edge clear done and go to IDLE.
- Latency:
  - Start accepted at edge E.
  - done=1 and diff/bout valid after edge E+WIDTH.
  - done clears after edge E+WIDTH+1.
  - Next start accepted at edge E+WIDTH+2 at the earliest.
- busy=1 exactly in SHIFT, i.e. for WIDTH cycles.
- start in SHIFT or DONE is ignored; no queuing.
- a, b and bin may change freely after acceptance without affecting the operation in flight.
- diff and bout change only when entering DONE and hold until the next completion.
- Arithmetic is modulo 2^WIDTH. bout=1 iff a < b + bin, unsigned.
- Reset mid-operation aborts the operation. diff and bout return to 0; no done pulse.
- done is never asserted for more than one cycle.

Optional Feature:
- Macro: SERSUB_ADD_MODE_EN.
- Defined:
  - Adds input port mode (1 bit), captured together with a and b.
  - mode=1 selects addition: d = a0^b0^c; c_next = (a0&b0) | (c&(a0^b0)); bin acts as carry-in; bout reports carry-out; diff holds a+b+cin.
  - mode=0 behaves exactly as the base subtractor.
  - Timing is identical in both modes.
- Undefined: no mode port; the block subtracts only.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulsed at edge E -> busy high for 8 cycles; done=1 after E+8; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Also a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Start a=0x10, b=0x01; pulse start again at E+3 with a=0x00, b=0x01 -> second request ignored; single done; diff=0x0F, bout=0.
- rst_n low for one cycle at E+4 of an operation -> no done pulse; diff=0, bout=0, busy=0. A fresh start afterwards completes normally.
- With SERSUB_ADD_MODE_EN and mode=1: a=0xFF, b=0x01, bin=0 -> diff=0x00, bout=1. a=0x7F, b=0x01, bin=1 -> diff=0x81, bout=0.
